ber_checker: RTL
================

# ber_checker

Bit-error-rate checker placed directly downstream of the FFE/LMS equalizer. It consumes the 1-bit slicer decision for each equalized symbol, which is the sign bit of the 9-bit FFE output (1 = symbol −1). It self-synchronizes a local PRBS9 (x^9+x^5+1) reference to the decision stream and counts compared bits and bit errors for the micro and the logger. Loss of lock is detected by windowed error density, and the checker then re-acquires automatically.

## Interface
- CNT_BW, 32: width of the bit and error counters.
- LOCK_WIN, 128: bits per verify window and per loss-check window (≥ 16).
- LOSS_THR, 16: errors within one LOCKED window that force loss of lock.
- clockdsp  in  1  DSP clock; the only clock.
- soft_reset  in  1  asynchronous, active-high reset.
- i_en  in  1  sample strobe; one decision consumed per cycle while high.
- i_decision  in  1  slicer decision bit (sign of FFE output).
- i_clear  in  1  synchronous clear of o_bit_cnt, o_err_cnt and o_loss_cnt.
- o_locked  out  1  high in LOCKED state.
- o_bit_cnt  out  CNT_BW  bits compared while LOCKED (saturating).
- o_err_cnt  out  CNT_BW  bit errors while LOCKED (saturating).
- o_loss_cnt  out  8  number of LOCKED→SEARCH transitions (saturating at 255).

## Operation
- Reference history h[8:0], h[0] newest. Predicted bit p = h[8] ^ h[4].
- Every state acts only on cycles with i_en = 1. With i_en = 0, all state, counters and history hold.
- SEARCH:
  - Shift i_decision into h.
  - After 9 shifts, check h. If h == 0, restart the 9-bit fill; the all-zero seed is degenerate. Otherwise go to VERIFY with the window counter set to 0.
- VERIFY:
  - Compare i_decision with p. Shift i_decision into h.
  - On the first mismatch, go to SEARCH and restart the fill.
  - After LOCK_WIN consecutive matches, go to LOCKED.
  - Counters do not change in this state.
- LOCKED:
  - Shift p, not i_decision, into h, so channel errors do not corrupt the reference.
  - o_bit_cnt += 1. o_err_cnt += (i_decision != p).
  - Window counter: err_win counts errors in the current LOCK_WIN-bit window and resets at each window end.
  - When err_win reaches LOSS_THR inside a window, go to SEARCH on that cycle and increment o_loss_cnt. o_bit_cnt and o_err_cnt hold their values.
- Saturation: when o_bit_cnt reaches all-ones, both o_bit_cnt and o_err_cnt freeze until i_clear. o_err_cnt never exceeds o_bit_cnt.
- i_clear:
  - Zeroes the three counters on the next edge.
  - State, history and window counters are unaffected.
  - If i_clear and a counted sample occur in the same cycle, the clear wins and that sample is not counted.

## Timing
- Reset (async assert): state = SEARCH, h = 0, fill/window/err_win counters = 0, o_locked = 0, o_bit_cnt = 0, o_err_cnt = 0, o_loss_cnt = 0.
- Reset may assert mid-operation in any state; all of the above apply immediately.
- All outputs are registered. A decision sampled at edge n is reflected in the counters and o_locked after edge n.
- Minimum acquisition from reset on an error-free stream: 9 + LOCK_WIN enabled cycles. o_locked rises at the edge that consumes the LOCK_WIN-th verify bit.
- A loss-of-lock edge: o_locked falls and o_loss_cnt increments in the same cycle. The triggering error is included in o_err_cnt.
- No backpressure. The block accepts every strobe.

## Structure
- Shared package ber_pkg holds:
  - state enum: SEARCH, VERIFY, LOCKED.
  - PRBS9 tap constants: 8 and 4.
  - PRBS_LEN = 9.
- One sub-module, prbs9_pred, holds the history register, the predictor and a load-vs-run select.
- Counters and the FSM live in ber_checker.
- The top-level DSP instance feeds i_decision from the FFE output sign bit and i_en from the module enable. o_err_cnt[7:0] may also drive a logger input.

## Test plan
- Clean PRBS9 stream (seed 9'h1FF), i_en always 1 → o_locked = 1 after exactly 137 cycles. After 1000 further cycles: o_bit_cnt = 1000, o_err_cnt = 0.
- Locked, then inject 5 isolated bit flips spaced 20 bits apart → o_err_cnt = 5, o_locked stays 1, o_loss_cnt = 0.
- Locked, then invert 16 consecutive bits → o_locked falls on the 16th error, o_loss_cnt = 1, o_err_cnt = 16. Clean stream resumes → relock after 137 enabled cycles with counters resumed, not cleared.
- All-zero input → state never leaves SEARCH, o_locked stays 0, counters stay 0.
- i_en toggling 1/0 on a clean stream → lock after 137 enabled cycles (274 clocks). i_clear asserted together with a valid sample → counters read 0 on the next cycle.
- CNT_BW = 4, clean stream, locked → o_bit_cnt saturates at 15 and holds. soft_reset pulsed mid-LOCKED → all outputs 0 immediately, state SEARCH.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared types and PRBS9 constants for the BER checker.
package ber_pkg;
  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} ber_state_t;
  localparam int PRBS_LEN = 9;
  localparam int TAP_HI   = 8;
  localparam int TAP_LO   = 4;
endpackage

// File: rtl/ber_checker_prbs9_pred.sv
// PRBS9 history and predictor; load selects the decision bit, otherwise self-runs.
module prbs9_pred
  import ber_pkg::*;
(
  input  logic                clockdsp,
  input  logic                soft_reset,
  input  logic                en,
  input  logic                load,
  input  logic                din,
  output logic [PRBS_LEN-1:0] hist,
  output logic                pred
);
  assign pred = hist[TAP_HI] ^ hist[TAP_LO];

  always_ff @(posedge clockdsp or posedge soft_reset) begin
    if (soft_reset) hist <= '0;
    else if (en)    hist <= {hist[PRBS_LEN-2:0], load ? din : pred};
  end
endmodule

// File: rtl/ber_checker.sv
// PRBS9 bit-error-rate checker: search/verify/locked FSM, windowed loss detect,
// saturating bit/error/loss counters.
module ber_checker
  import ber_pkg::*;
#(
  parameter int CNT_BW   = 32,
  parameter int LOCK_WIN = 128,
  parameter int LOSS_THR = 16
) (
  input  logic              clockdsp,
  input  logic              soft_reset,
  input  logic              i_en,
  input  logic              i_decision,
  input  logic              i_clear,
  output logic              o_locked,
  output logic [CNT_BW-1:0] o_bit_cnt,
  output logic [CNT_BW-1:0] o_err_cnt,
  output logic [7:0]        o_loss_cnt
);
  localparam int WIN_W = $clog2(LOCK_WIN);
  localparam int ERR_W = $clog2(LOSS_THR + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(LOCK_WIN - 1);

  ber_state_t          state, state_n;
  logic [3:0]          fill, fill_n;
  logic [WIN_W-1:0]    win, win_n;
  logic [ERR_W-1:0]    errw, errw_n;
  logic                load, count, loss, mis;
  logic [PRBS_LEN-1:0] hist, shifted;
  logic                pred;

  prbs9_pred u_pred (
    .clockdsp  (clockdsp),
    .soft_reset(soft_reset),
    .en        (i_en),
    .load      (load),
    .din       (i_decision),
    .hist      (hist),
    .pred      (pred)
  );

  assign mis      = i_decision ^ pred;
  assign shifted  = {hist[PRBS_LEN-2:0], i_decision};
  assign o_locked = (state == LOCKED);

  always_ff @(posedge clockdsp or posedge soft_reset) begin
    if (soft_reset) begin
      state <= SEARCH;
      fill  <= '0;
      win   <= '0;
      errw  <= '0;
    end else begin
      state <= state_n;
      fill  <= fill_n;
      win   <= win_n;
      errw  <= errw_n;
    end
  end

  always_comb begin
    state_n = state;
    fill_n  = fill;
    win_n   = win;
    errw_n  = errw;
    load    = 1'b1;
    count   = 1'b0;
    loss    = 1'b0;
    if (i_en) begin
      case (state)
        SEARCH: begin
          if (fill == 4'(PRBS_LEN - 1)) begin
            fill_n = '0;
            // all-zero seed locks the predictor at zero forever; refill instead
            if (shifted != '0) begin
              state_n = VERIFY;
              win_n   = '0;
            end
          end else begin
            fill_n = fill + 4'd1;
          end
        end
        VERIFY: begin
          if (mis) begin
            state_n = SEARCH;
            fill_n  = '0;
          end else if (win == WIN_LAST) begin
            state_n = LOCKED;
            win_n   = '0;
            errw_n  = '0;
          end else begin
            win_n = win + WIN_W'(1);
          end
        end
        LOCKED: begin
          load  = 1'b0;
          count = 1'b1;
          if (win == WIN_LAST) begin
            win_n  = '0;
            errw_n = '0;
          end else begin
            win_n  = win + WIN_W'(1);
            errw_n = errw + ERR_W'(mis);
          end
          if ((errw + ERR_W'(mis)) == ERR_W'(LOSS_THR)) begin
            loss    = 1'b1;
            state_n = SEARCH;
            fill_n  = '0;
            win_n   = '0;
            errw_n  = '0;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clockdsp or posedge soft_reset) begin
    if (soft_reset) begin
      o_bit_cnt  <= '0;
      o_err_cnt  <= '0;
      o_loss_cnt <= '0;
    end else if (i_clear) begin
      o_bit_cnt  <= '0;
      o_err_cnt  <= '0;
      o_loss_cnt <= '0;
    end else if (count) begin
      // bit counter saturation freezes both so err never overtakes bits
      if (o_bit_cnt != '1) begin
        o_bit_cnt <= o_bit_cnt + CNT_BW'(1);
        o_err_cnt <= o_err_cnt + CNT_BW'(mis);
      end
      if (loss && o_loss_cnt != 8'hFF) o_loss_cnt <= o_loss_cnt + 8'd1;
    end
  end
endmodule
